// File: rtl/branch_resolver.sv
// Resolves EX control flow against the IF prediction: issues a one-cycle redirect/flush on a mispredict
// and queues conditional-branch outcomes as predictor training updates, delivered when IF is not doing a lookup.
module branch_resolver #(
    parameter int QDEPTH = 4,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    input  logic [PC_W-1:0]  br_pc,
    input  logic             br_is_cond,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    input  logic [PC_W-1:0]  br_pred_pc,
    input  logic             get_predict,
    output logic             update_predict,
    output logic             jump,
    output logic [PC_W-1:0]  last_branch_pc,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush,
    output logic             stall_ex,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count,
    output logic [CNT_W-1:0] drop_count
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]   q_pc [QDEPTH];
    logic [QDEPTH-1:0] q_taken;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;

    logic              accept_p0;
    logic [PC_W-1:0]   next_pc_p0;
    logic              mispredict_p0;
    logic              push_req_p0;
    logic              push;
    logic              pop;
    logic              empty;
    logic              full;
    logic              drop;

    // Stage p0: resolve the branch presented by EX; a flush cycle marks it as wrong-path
    always_comb begin
        accept_p0     = br_valid & ~flush;
        next_pc_p0    = br_taken ? br_target : (br_pc + PC_W'(4));
        mispredict_p0 = accept_p0 & (next_pc_p0 != br_pred_pc);
        push_req_p0   = accept_p0 & br_is_cond;
    end

    always_comb begin
        empty = (count == '0);
        full  = (count == CW'(QDEPTH));
        pop   = ~empty & ~get_predict;
        // A full queue can still accept when the head leaves in the same cycle
        push  = push_req_p0 & (~full | pop);
        drop  = push_req_p0 & full & ~pop;
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    assign update_predict = pop;
    assign stall_ex       = full;
    assign jump           = pop & q_taken[rd_ptr];
    assign last_branch_pc = pop ? q_pc[rd_ptr] : '0;

    // Queue storage holds no state that matters while empty, so it is not reset
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= br_pc;
            q_taken[wr_ptr] <= br_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
        end
    end

    // Stage p1: registered redirect, flush and performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid   <= 1'b0;
            flush            <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
            drop_count       <= '0;
        end else begin
            redirect_valid <= mispredict_p0;
            flush          <= mispredict_p0;
            if (mispredict_p0) redirect_pc <= next_pc_p0;
            branch_count     <= branch_count + CNT_W'(accept_p0);
            mispredict_count <= mispredict_count + CNT_W'(mispredict_p0);
            drop_count       <= drop_count + CNT_W'(drop);
        end
    end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

EX-side partner of the branch predictor. Takes each resolved branch/jump from EX and compares its real next PC against the PC that IF predicted. On a mismatch it issues a one-cycle redirect and flush. For conditional branches it queues a training update (`update_predict` / `jump` / `last_branch_pc`). Each update is delivered only in a cycle when IF is not using the predictor (`get_predict` low), because the predictor serves lookups before updates.

## Interface
Parameters:
- `QDEPTH`, 4: update queue entries, power of two ≥2.
- `PC_W`, 32: PC width (`InstAddrBus`).
- `CNT_W`, 32: performance counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `br_valid` in 1: EX resolved a control-flow instruction this cycle.
- `br_pc` in PC_W: PC of that instruction.
- `br_is_cond` in 1: 1 = conditional branch, 0 = JAL/JALR.
- `br_taken` in 1: actual direction (EX drives 1 for JAL/JALR).
- `br_target` in PC_W: actual taken target.
- `br_pred_pc` in PC_W: next PC that IF fetched after this instruction.
- `get_predict` in 1: IF is performing a predictor lookup this cycle.
- `update_predict` out 1: predictor training strobe.
- `jump` out 1: trained outcome.
- `last_branch_pc` out PC_W: PC being trained.
- `redirect_valid` out 1: IF must restart at `redirect_pc`.
- `redirect_pc` out PC_W: correct fetch PC.
- `flush` out 1: kill younger instructions in IF/ID/EX.
- `stall_ex` out 1: queue full; EX must hold `br_valid` low.
- `branch_count` out CNT_W: resolved branches.
- `mispredict_count` out CNT_W: mispredictions.
- `drop_count` out CNT_W: updates lost to overflow.

## Operation
- **Accepted branch:** `br_valid & ~flush`. In a cycle with `flush` high, `br_valid` is ignored entirely, because the instruction is wrong-path.
- **Actual next PC:** `br_taken ? br_target : br_pc + 4`. Addition is modulo 2^PC_W, so `0xFFFFFFFC` + 4 gives 0.
- **Mispredict:** actual next PC ≠ `br_pred_pc`. This covers both a wrong direction and a wrong target.
- **Redirect on mispredict:** the next cycle has `redirect_valid` = `flush` = 1 and `redirect_pc` = actual next PC, held for exactly one cycle. Otherwise `redirect_valid` = `flush` = 0 and `redirect_pc` holds its last value.
- **Counters:** `branch_count` +1 per accepted branch. `mispredict_count` +1 per mispredicted accepted branch. Both wrap at 2^CNT_W.
- **Enqueue:** an accepted branch with `br_is_cond` = 1 pushes {`br_pc`, `br_taken`}. JAL/JALR never push.
- **Drain:** `update_predict` = `~empty & ~get_predict`, combinational. `jump` and `last_branch_pc` show the head entry when `update_predict` = 1, else 0. A head entry is popped in every cycle `update_predict` = 1.
- **Order:** FIFO, so updates reach the predictor in resolution order.
- **Full:** `stall_ex` = (count == QDEPTH), combinational.
- **Push + pop in the same cycle:** allowed at any occupancy, including full; count is unchanged.
- **Push when full with no pop:** violation of the `stall_ex` rule. The entry is dropped, `drop_count` +1, and redirect/counters still act normally.
- **No bypass:** an entry pushed in cycle t is visible at the head in t+1 at the earliest.
- **Reset:** queue empty and pointers zeroed. `update_predict`, `jump`, `last_branch_pc`, `redirect_valid`, `redirect_pc`, `flush`, `stall_ex` and all counters are 0. A pending redirect is cancelled.

## Timing
- Redirect/flush latency: 1 cycle after an accepted `br_valid`.
- Update latency: at least 1 cycle after enqueue. After that, the entry goes out in the first cycle where it is the head and `get_predict` = 0.
- Sustained throughput: one update per cycle while `get_predict` = 0.
- `update_predict` and `stall_ex` are combinational from state and `get_predict`. All other outputs are registered.
- Reset asserted mid-operation takes effect at the next edge. Queued updates are discarded and no strobe follows in later cycles.

## Test plan
- **Correct prediction:** BEQ `br_pc`=0x100, taken, target 0x80, `br_pred_pc`=0x80, `get_predict`=0. Next cycle: no redirect, `update_predict`=1, `jump`=1, `last_branch_pc`=0x100, `branch_count`=1, `mispredict_count`=0.
- **Direction mispredict:** BNE `br_pc`=0x200, not taken, `br_pred_pc`=0x180. Next cycle: `redirect_valid`=`flush`=1 for one cycle, `redirect_pc`=0x204. A `br_valid` presented during the flush cycle is ignored and `branch_count` stays 1.
- **JALR target mispredict:** `br_target`=0x3000, `br_pred_pc`=0x2004. Response: redirect to 0x3000 and no update strobe ever.
- **Predictor contention:** enqueue 0x10/taken and then 0x20/not-taken while holding `get_predict`=1 for 5 cycles. No strobe during those cycles. After release, strobes for 0x10 (`jump`=1) then 0x20 (`jump`=0) on consecutive cycles.
- **Full queue:** fill QDEPTH=4 with `get_predict`=1, so `stall_ex`=1. A forced fifth branch gives `drop_count`=1. Push and release `get_predict` in the same cycle, and occupancy stays 4.
- **Reset mid-operation:** assert `rst` with 3 queued entries and a redirect pending. Response: all outputs 0, no strobes after reset.
